alu_arbiter: RTL

- Shares one combinational alu instance between two requesters: issue port 0 and issue port 1.
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Operands are registered before the ALU and the result after it, so the block closes timing around the ALU critical path (carry-select add, booth multiply).
- Sits between the control unit's two issue sources and the single datapath ALU.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SEL_W_DEF  = 3;
  localparam int unsigned TAG_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [SEL_W_DEF-1:0] OP_AND = 3'b000;
  localparam logic [SEL_W_DEF-1:0] OP_OR  = 3'b001;
  localparam logic [SEL_W_DEF-1:0] OP_ADD = 3'b010;
  localparam logic [SEL_W_DEF-1:0] OP_SLL = 3'b011;
  localparam logic [SEL_W_DEF-1:0] OP_MUL = 3'b100;
  localparam logic [SEL_W_DEF-1:0] OP_SRL = 3'b101;
  localparam logic [SEL_W_DEF-1:0] OP_SUB = 3'b110;
  localparam logic [SEL_W_DEF-1:0] OP_SLT = 3'b111;

  // Only add and subtract produce a meaningful overflow flag.
  function automatic logic op_has_of(input logic [SEL_W_DEF-1:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention the
// port that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready issue ports,
// with registered operands and result. Optional counters: ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp0_of,
  output logic              rsp1_of,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic [TAG_W-1:0]  rsp1_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_of
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]       stat_ops0,
  output logic [31:0]       stat_ops1,
  output logic [31:0]       stat_stall
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_port;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [SEL_W-1:0]  r_sel;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_result;
  logic              r_of;

  logic [1:0]        w_req_valid;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_rsp_hs;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [SEL_W-1:0]  w_sel;
  logic [TAG_W-1:0]  w_tag;

  // Ready is held low while reset is asserted so nothing is accepted then.
  assign w_req_valid = ((r_state == IDLE) && rst_n) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .i_valid      (w_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_accept   = |w_grant;
  assign w_rsp_hs   = (r_state == RESP) && (r_port ? rsp1_ready : rsp0_ready);

  always_comb begin
    w_a   = req0_a;
    w_b   = req0_b;
    w_sel = req0_sel;
    w_tag = req0_tag;
    if (w_grant[1]) begin
      w_a   = req1_a;
      w_b   = req1_b;
      w_sel = req1_sel;
      w_tag = req1_tag;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_sel        <= '0;
      r_tag        <= '0;
      r_result     <= '0;
      r_of         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_accept) begin
        r_a          <= w_a;
        r_b          <= w_b;
        r_sel        <= w_sel;
        r_tag        <= w_tag;
        r_port       <= w_grant[1];
        r_last_grant <= w_grant[1];
      end
      if (r_state == EXEC) begin
        r_result <= alu_result;
        r_of     <= op_has_of(SEL_W_DEF'(r_sel)) ? alu_of : 1'b0;
      end
    end
  end

  assign rsp0_valid  = (r_state == RESP) && !r_port;
  assign rsp1_valid  = (r_state == RESP) && r_port;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_of     = r_of;
  assign rsp1_of     = r_of;
  assign rsp0_tag    = r_tag;
  assign rsp1_tag    = r_tag;

  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sel = r_sel;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_ops0;
  logic [31:0] r_ops1;
  logic [31:0] r_stall;
  logic        w_stall;

  assign w_stall = (req0_valid | req1_valid) & ~w_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ops0  <= '0;
      r_ops1  <= '0;
      r_stall <= '0;
    end else begin
      if (w_rsp_hs && !r_port) r_ops0 <= r_ops0 + 32'd1;
      if (w_rsp_hs && r_port)  r_ops1 <= r_ops1 + 32'd1;
      if (w_stall && (r_stall != '1)) r_stall <= r_stall + 32'd1;
    end
  end

  assign stat_ops0  = r_ops0;
  assign stat_ops1  = r_ops1;
  assign stat_stall = r_stall;
`endif

endmodule
